eq_gain_ctrl: RTL

- Gain controller for the 10-band equalizer datapath.
- Holds shadow and target gain registers, written by a host-side write port.
- Ramps the live gains toward their targets by at most STEP per audio sample, to avoid zipper noise.
- Publishes a coherent 10-gain set that drives gain_1..gain_10 of the equalizer.

---
 rtl/eq_ctrl_pkg.sv | 15 +
 rtl/eq_gain_stepper.sv | 27 ++
 rtl/eq_gain_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/eq_ctrl_pkg.sv
// Shared constants and types for the equalizer gain controller.
package eq_ctrl_pkg;
  localparam int NUM_BANDS  = 10;
  localparam int BAND_IDX_W = 4;

  // Band index to equalizer port: band b drives gain_(b+1).
  localparam logic [BAND_IDX_W-1:0] BAND_LOWPASS  = 4'd0;
  localparam logic [BAND_IDX_W-1:0] BAND_HIGHPASS = 4'd9;

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  function automatic logic band_ok(input logic [BAND_IDX_W-1:0] b);
    return b <= BAND_HIGHPASS;
  endfunction
endpackage

// File: rtl/eq_gain_stepper.sv
// Moves one gain toward its target by at most STEP, landing exactly on the target.
module eq_gain_stepper #(
  parameter int W    = 8,
  parameter int STEP = 4
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] nxt
);
  logic [W:0] c, t, d, s;

  always_comb begin
    c   = {1'b0, cur};
    t   = {1'b0, tgt};
    s   = (W+1)'(STEP);
    d   = '0;
    nxt = tgt;
    // One extra bit keeps cur +/- STEP from wrapping near the rails.
    if (t > c) begin
      d = t - c;
      if (d > s) nxt = W'(c + s);
    end else begin
      d = c - t;
      if (d > s) nxt = W'(c - s);
    end
  end
endmodule

// File: rtl/eq_gain_ctrl.sv
// Shadow/target gain registers with a per-sample scan that ramps live gains and publishes them as one set.
module eq_gain_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int GAIN_WIDTH = 8,
  parameter int STEP       = 4,
  parameter int RESET_GAIN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_band,
  input  logic [GAIN_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic                  commit,
  input  logic                  mute,
  input  logic                  sample_tick,
  output logic [GAIN_WIDTH-1:0] gain_1,
  output logic [GAIN_WIDTH-1:0] gain_2,
  output logic [GAIN_WIDTH-1:0] gain_3,
  output logic [GAIN_WIDTH-1:0] gain_4,
  output logic [GAIN_WIDTH-1:0] gain_5,
  output logic [GAIN_WIDTH-1:0] gain_6,
  output logic [GAIN_WIDTH-1:0] gain_7,
  output logic [GAIN_WIDTH-1:0] gain_8,
  output logic [GAIN_WIDTH-1:0] gain_9,
  output logic [GAIN_WIDTH-1:0] gain_10,
  output logic                  gains_valid,
  output logic                  busy,
  output logic                  ramping,
  output logic                  overrun,
  input  logic                  overrun_clr
);
  localparam logic [GAIN_WIDTH-1:0] RST_G = GAIN_WIDTH'(RESET_GAIN);

  typedef logic [NUM_BANDS-1:0][GAIN_WIDTH-1:0] gset_t;

  state_t                state_q, state_d;
  logic [BAND_IDX_W-1:0] cnt_q;
  gset_t                 shadow_q, shadow_d, target_q, work_q, pub_q;
  logic                  pend_q;
  logic                  scan_en, pub_en, start;
  logic [GAIN_WIDTH-1:0] eff_cur, step_nxt;
  logic [NUM_BANDS-1:0]  mis;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick) state_d = SCAN;
      SCAN:    if (cnt_q == BAND_HIGHPASS) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = state_q != IDLE;
  assign start   = state_q == IDLE && sample_tick;
  assign scan_en = state_q == SCAN;
  assign pub_en  = state_q == PUBLISH;

  // A same-cycle write is visible to a same-cycle commit copy.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && band_ok(wr_band)) shadow_d[wr_band] = wr_data;
  end

  // Single stepper shared by all bands through the scan mux.
  assign eff_cur = mute ? '0 : target_q[cnt_q];

  eq_gain_stepper #(.W(GAIN_WIDTH), .STEP(STEP)) u_step (
    .cur (work_q[cnt_q]),
    .tgt (eff_cur),
    .nxt (step_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= {NUM_BANDS{RST_G}};
      target_q    <= {NUM_BANDS{RST_G}};
      work_q      <= {NUM_BANDS{RST_G}};
      pub_q       <= {NUM_BANDS{RST_G}};
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      wr_err      <= 1'b0;
      gains_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      wr_err      <= wr_en && !band_ok(wr_band);
      gains_valid <= pub_en;

      if (start)        cnt_q <= '0;
      else if (scan_en) cnt_q <= cnt_q + 4'd1;

      if (scan_en) work_q[cnt_q] <= step_nxt;

      // Targets only move in IDLE or PUBLISH, never mid-scan.
      if (pub_en) begin
        pub_q  <= work_q;
        pend_q <= 1'b0;
        if (pend_q || commit) target_q <= shadow_d;
      end else if (commit) begin
        if (state_q == IDLE) target_q <= shadow_d;
        else                 pend_q   <= 1'b1;
      end

      if (sample_tick && busy) overrun <= 1'b1;
      else if (overrun_clr)    overrun <= 1'b0;
    end
  end

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_cmp
    assign mis[b] = pub_q[b] != (mute ? {GAIN_WIDTH{1'b0}} : target_q[b]);
  end
  assign ramping = |mis;

  assign gain_1  = pub_q[BAND_LOWPASS];
  assign gain_2  = pub_q[1];
  assign gain_3  = pub_q[2];
  assign gain_4  = pub_q[3];
  assign gain_5  = pub_q[4];
  assign gain_6  = pub_q[5];
  assign gain_7  = pub_q[6];
  assign gain_8  = pub_q[7];
  assign gain_9  = pub_q[8];
  assign gain_10 = pub_q[BAND_HIGHPASS];
endmodule
